// File: rtl/bcd_digit_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_assembler_pkg
// Description : Shared constants for the BCD digit assembler. Holds the
//               largest legal BCD digit, the FSM state encoding and the
//               usual range limits for minutes and hours entry.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_digit_assembler_pkg;

    // Largest legal BCD digit
    localparam logic [3:0] BCD_MAX     = 4'd9;

    // Typical MAX_VALUE settings for time-set entry
    localparam int         MINUTES_MAX = 59;
    localparam int         HOURS_MAX   = 23;

    // FSM state encoding
    localparam int         STATE_W     = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;  // no digits accepted
    localparam logic [1:0] c_ST_ACCUM  = 2'd1;  // 1..NUM_DIGITS-1 digits held
    localparam logic [1:0] c_ST_CHECK  = 2'd2;  // all digits in, range check
    localparam logic [1:0] c_ST_DONE   = 2'd3;  // result strobe

    // True when the nibble is a legal decimal digit
    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_assembler_mul10_add.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_assembler_mul10_add
// Description : Combinational acc*10 + digit using shift-add
//               ((acc<<3) + (acc<<1) + digit). The sum is formed four bits
//               wider than the accumulator; if it does not fit it saturates
//               to all ones instead of wrapping, so an oversized entry can
//               never alias back into the legal range.
// Ports       : i_acc   - current accumulator
//               i_digit - digit to append (any nibble value)
//               o_sum   - saturated acc*10 + digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_assembler_mul10_add #(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [3:0]       i_digit,
    output logic [ACC_W-1:0] o_sum
);

    logic [ACC_W+3:0] w_acc_ext;
    logic [ACC_W+3:0] w_wide;

    assign w_acc_ext = {4'b0000, i_acc};

    // acc*10 + 15 < 16*(acc+1), so ACC_W+4 bits always holds the full sum
    assign w_wide = (w_acc_ext << 3) + (w_acc_ext << 1)
                  + {{ACC_W{1'b0}}, i_digit};

    assign o_sum = (|w_wide[ACC_W+3:ACC_W]) ? {ACC_W{1'b1}}
                                            : w_wide[ACC_W-1:0];

endmodule
`default_nettype wire

// File: rtl/bcd_digit_assembler.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_assembler
// Description : Sequential BCD-to-binary assembler. Digits arrive most
//               significant first over a valid/ready handshake and are
//               folded into acc = acc*10 + digit. After NUM_DIGITS digits
//               the result is range-checked and presented on value_out with
//               a one-cycle value_valid strobe.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               digit_in      - BCD digit, MS digit first
//               digit_valid   - digit_in valid this cycle
//               digit_ready   - assembler can accept a digit
//               clear         - abort current entry
//               value_out     - last good binary value, held
//               value_valid   - one-cycle strobe, value_out/value_err updated
//               value_err     - last result invalid
//               busy          - an entry is in progress
//               digit_count   - digits accepted in current entry
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_assembler
    import bcd_digit_assembler_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int OUT_W      = 6,
    parameter int MAX_VALUE  = MINUTES_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       digit_in,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic             clear,
    output logic [OUT_W-1:0] value_out,
    output logic             value_valid,
    output logic             value_err,
    output logic             busy,
    output logic [2:0]       digit_count
);

    localparam int               ACC_W        = OUT_W + 4;
    localparam logic [2:0]       c_NUM_DIGITS = 3'(NUM_DIGITS);
    localparam logic [ACC_W-1:0] c_MAX_ACC    = ACC_W'(MAX_VALUE);

    logic [STATE_W-1:0] r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [2:0]         r_count;
    logic               r_bad_digit;
    logic [OUT_W-1:0]   r_value;
    logic               r_err;

    logic               w_accept;
    logic [ACC_W-1:0]   w_acc_next;
    logic [2:0]         w_count_next;
    logic               w_last_digit;
    logic               w_result_err;

    bcd_digit_assembler_mul10_add #(
        .ACC_W   (ACC_W)
    ) u_mul10_add (
        .i_acc   (r_acc),
        .i_digit (digit_in),
        .o_sum   (w_acc_next)
    );

    assign digit_ready  = (r_state == c_ST_IDLE) || (r_state == c_ST_ACCUM);
    // clear drops any digit presented alongside it
    assign w_accept     = digit_valid && digit_ready && !clear;
    assign w_count_next = r_count + 3'd1;
    assign w_last_digit = (w_count_next == c_NUM_DIGITS);
    assign w_result_err = r_bad_digit || (r_acc > c_MAX_ACC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_bad_digit <= 1'b0;
            r_value     <= '0;
            r_err       <= 1'b0;
        end else if (clear) begin
            // Abort: entry state only, the last reported result is kept
            r_state     <= c_ST_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_bad_digit <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc       <= w_acc_next;
                        r_count     <= w_count_next;
                        // Non-BCD digit still accumulates; the result is discarded
                        r_bad_digit <= r_bad_digit | !is_bcd(digit_in);
                        r_state     <= w_last_digit ? c_ST_CHECK : c_ST_ACCUM;
                    end
                end
                c_ST_CHECK: begin
                    if (!w_result_err) begin
                        r_value <= r_acc[OUT_W-1:0];
                    end
                    r_err   <= w_result_err;
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_acc       <= '0;
                    r_count     <= '0;
                    r_bad_digit <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Strobe is masked by a coincident clear so an aborted entry never reports
    assign value_valid = (r_state == c_ST_DONE) && !clear;
    assign value_out   = r_value;
    assign value_err   = r_err;
    assign busy        = (r_state != c_ST_IDLE);
    assign digit_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_digit_assembler
// Description : Self-checking bench for bcd_digit_assembler (2 digits,
//               6-bit result, max 59). Expected results are queued when an
//               entry is driven and popped when value_valid strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_digit_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit_in = 4'd0;
    logic       digit_valid = 1'b0;
    logic       clear = 1'b0;
    logic       digit_ready;
    logic [5:0] value_out;
    logic       value_valid;
    logic       value_err;
    logic       busy;
    logic [2:0] digit_count;

    bcd_digit_assembler #(
        .NUM_DIGITS (2),
        .OUT_W      (6),
        .MAX_VALUE  (59)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .clear       (clear),
        .value_out   (value_out),
        .value_valid (value_valid),
        .value_err   (value_err),
        .busy        (busy),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] v;
        logic       e;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   strobes = 0;
    int   strobe_cyc = 0;
    int   last_acc_cyc = 0;
    logic prev_vv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe pops one expected result
    always @(negedge clk) begin
        if (rst) begin
            prev_vv = 1'b0;
        end else begin
            if (value_valid) begin
                strobes++;
                strobe_cyc = cyc;
                total++;
                if (prev_vv) begin
                    bad++;
                    $display("FAIL strobe_width: value_valid high 2 cycles at cyc %0d, required 1", cyc);
                end
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: value_out=%0d err=%0b, no result expected", value_out, value_err);
                end else begin
                    mon_e = q.pop_front();
                    total++;
                    if (value_out !== mon_e.v) begin
                        bad++;
                        $display("FAIL value_out: got %0d, required %0d", value_out, mon_e.v);
                    end
                    total++;
                    if (value_err !== mon_e.e) begin
                        bad++;
                        $display("FAIL value_err: got %0b, required %0b (value_out=%0d)", value_err, mon_e.e, value_out);
                    end
                end
            end
            prev_vv = value_valid;
        end
    end

    // Present a digit and hold it until accepted; returns at posedge+1 with
    // digit_valid still high. waits = cycles spent with digit_ready low.
    task automatic send_digit(input logic [3:0] d, output int waits);
        logic r;
        int   a;
        digit_in    = d;
        digit_valid = 1'b1;
        waits       = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r = digit_ready;
            a = cyc;
            @(posedge clk);
            #1;
            if (r) begin
                last_acc_cyc = a;
                return;
            end
            waits++;
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: digit %0d not accepted in 20 cycles", d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobes(input int target);
        for (int i = 0; i < 40; i++) begin
            if (strobes >= target) break;
            tick();
        end
        total++;
        if (strobes < target) begin
            bad++;
            $display("FAIL strobe_timeout: strobes=%0d, required %0d", strobes, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (value_out !== 6'd0) begin bad++; $display("FAIL rst_value_out: got %0d, required 0", value_out); end
        total++; if (value_valid !== 1'b0) begin bad++; $display("FAIL rst_value_valid: got %0b, required 0", value_valid); end
        total++; if (value_err !== 1'b0) begin bad++; $display("FAIL rst_value_err: got %0b, required 0", value_err); end
        total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL rst_digit_count: got %0d, required 0", digit_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b, required 0", busy); end
        total++; if (digit_ready !== 1'b1) begin bad++; $display("FAIL rst_digit_ready: got %0b, required 1", digit_ready); end
        tick();
    endtask

    task automatic test_basic();
        int w;
        int n0;
        int acc;
        n0 = strobes;
        q.push_back({6'd42, 1'b0});
        send_digit(4'd4, w);
        send_digit(4'd2, w);
        acc = last_acc_cyc;
        digit_valid = 1'b0;
        @(negedge clk);
        total++; if (digit_count !== 3'd2) begin bad++; $display("FAIL check_count: got %0d, required 2", digit_count); end
        total++; if (digit_ready !== 1'b0) begin bad++; $display("FAIL check_ready: got %0b, required 0", digit_ready); end
        wait_strobes(n0 + 1);
        total++; if (strobe_cyc - acc !== 2) begin bad++; $display("FAIL latency: got %0d, required 2", strobe_cyc - acc); end
        @(negedge clk);
        total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL post_count: got %0d, required 0", digit_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_busy: got %0b, required 0", busy); end
        tick();
    endtask

    task automatic test_range();
        int w;
        int n0;
        n0 = strobes;
        q.push_back({6'd59, 1'b0});
        send_digit(4'd5, w);
        send_digit(4'd9, w);
        digit_valid = 1'b0;
        wait_strobes(n0 + 1);
        q.push_back({6'd59, 1'b1});
        send_digit(4'd6, w);
        send_digit(4'd0, w);
        digit_valid = 1'b0;
        wait_strobes(n0 + 2);
        tick();
    endtask

    task automatic test_bad_digit();
        int w;
        int n0;
        n0 = strobes;
        q.push_back({6'd59, 1'b1});
        send_digit(4'hA, w);
        send_digit(4'd3, w);
        digit_valid = 1'b0;
        wait_strobes(n0 + 1);
        q.push_back({6'd7, 1'b0});
        send_digit(4'd0, w);
        send_digit(4'd7, w);
        digit_valid = 1'b0;
        wait_strobes(n0 + 2);
        tick();
    endtask

    task automatic test_clear();
        int w;
        int n0;
        n0 = strobes;
        send_digit(4'd3, w);
        digit_valid = 1'b0;
        clear = 1'b1;
        digit_valid = 1'b1;
        digit_in = 4'd1;
        tick();
        clear = 1'b0;
        digit_valid = 1'b0;
        @(negedge clk);
        total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL clear_count: got %0d, required 0", digit_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy: got %0b, required 0", busy); end
        repeat (5) tick();
        total++; if (strobes !== n0) begin bad++; $display("FAIL clear_strobe: got %0d strobes, required %0d", strobes, n0); end
        q.push_back({6'd15, 1'b0});
        send_digit(4'd1, w);
        send_digit(4'd5, w);
        digit_valid = 1'b0;
        wait_strobes(n0 + 1);
        tick();
        // clear landing on the CHECK cycle suppresses the result entirely
        n0 = strobes;
        send_digit(4'd2, w);
        send_digit(4'd2, w);
        digit_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (5) tick();
        total++; if (strobes !== n0) begin bad++; $display("FAIL clear_check_strobe: got %0d strobes, required %0d", strobes, n0); end
        @(negedge clk);
        total++; if (value_out !== 6'd15) begin bad++; $display("FAIL clear_check_value: got %0d, required 15", value_out); end
        tick();
    endtask

    task automatic test_hold();
        int w;
        int n0;
        int acc8;
        n0 = strobes;
        q.push_back({6'd12, 1'b0});
        send_digit(4'd1, w);
        send_digit(4'd2, w);
        send_digit(4'd8, w);
        acc8 = last_acc_cyc;
        digit_valid = 1'b0;
        total++; if (w !== 2) begin bad++; $display("FAIL hold_waits: got %0d, required 2", w); end
        total++; if (acc8 - strobe_cyc !== 1) begin bad++; $display("FAIL hold_accept_cyc: got %0d after strobe, required 1", acc8 - strobe_cyc); end
        @(negedge clk);
        total++; if (digit_count !== 3'd1) begin bad++; $display("FAIL hold_count: got %0d, required 1", digit_count); end
        tick();
        q.push_back({6'd12, 1'b1});
        send_digit(4'd3, w);
        digit_valid = 1'b0;
        wait_strobes(n0 + 2);
        tick();
    endtask

    task automatic test_back_to_back();
        int w;
        int n0;
        int first;
        logic [3:0] ds[8];
        ds = '{4'd1, 4'd0, 4'd2, 4'd0, 4'd3, 4'd3, 4'd5, 4'd0};
        n0 = strobes;
        q.push_back({6'd10, 1'b0});
        q.push_back({6'd20, 1'b0});
        q.push_back({6'd33, 1'b0});
        q.push_back({6'd50, 1'b0});
        send_digit(ds[0], w);
        first = last_acc_cyc;
        for (int i = 1; i < 8; i++) send_digit(ds[i], w);
        digit_valid = 1'b0;
        wait_strobes(n0 + 4);
        // four entries at NUM_DIGITS+2 = 4 cycles each, last strobe 2 after last accept
        total++; if (strobe_cyc - first !== 15) begin bad++; $display("FAIL b2b_span: got %0d cycles, required 15", strobe_cyc - first); end
        tick();
    endtask

    task automatic test_reset_mid();
        int w;
        int n0;
        int acc;
        send_digit(4'd2, w);
        digit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (value_out !== 6'd0) begin bad++; $display("FAIL mid_rst_value_out: got %0d, required 0", value_out); end
        total++; if (value_err !== 1'b0) begin bad++; $display("FAIL mid_rst_value_err: got %0b, required 0", value_err); end
        total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL mid_rst_count: got %0d, required 0", digit_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0b, required 0", busy); end
        total++; if (digit_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %0b, required 1", digit_ready); end
        tick();
        n0 = strobes;
        q.push_back({6'd23, 1'b0});
        send_digit(4'd2, w);
        send_digit(4'd3, w);
        acc = last_acc_cyc;
        digit_valid = 1'b0;
        wait_strobes(n0 + 1);
        total++; if (strobe_cyc - acc !== 2) begin bad++; $display("FAIL mid_rst_latency: got %0d, required 2", strobe_cyc - acc); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_bad_digit();
        test_clear();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        repeat (3) tick();
        total++;
        if (q.size() !== 0) begin
            bad++;
            $display("FAIL leftover_results: %0d expected results never strobed, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
